// File: rtl/pe_axi_rd_arb_pkg.sv
// Shared types and constants for the PE AXI4-Lite read arbiter.
package pe_axi_rd_arb_pkg;

   // Width of grant_id / last_grant; covers up to 8 requesters.
   localparam int unsigned GrantIdW = 3;

   // Arbiter FSM state encoding.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAddr  = 2'd1,
      StData  = 2'd2,
      StDrain = 2'd3
   } state_e;

   // AXI read response codes.
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/pe_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at last_grant+1 and wraps.
module pe_rr_arbiter
   import pe_axi_rd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [GrantIdW-1:0] last_grant_i,
   output logic [NUM_REQ-1:0]  grant_oh_o,
   output logic [GrantIdW-1:0] grant_idx_o,
   output logic                grant_valid_o
);

   // Two passes: first requesters above last_grant, then wrap to the lowest index.
   always_comb begin
      grant_oh_o    = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!grant_valid_o && req_i[i] && (GrantIdW'(i) > last_grant_i)) begin
            grant_valid_o = 1'b1;
            grant_oh_o[i] = 1'b1;
            grant_idx_o   = GrantIdW'(i);
         end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!grant_valid_o && req_i[i]) begin
            grant_valid_o = 1'b1;
            grant_oh_o[i] = 1'b1;
            grant_idx_o   = GrantIdW'(i);
         end
      end
   end

endmodule

// File: rtl/pe_axi_rd_arb.sv
// Round-robin AXI4-Lite read arbiter: NUM_REQ PE requesters onto one master port,
// one outstanding transaction at a time.
// Optional R-channel timeout compiled in with macro PE_AXI_RD_ARB_TIMEOUT_EN.
module pe_axi_rd_arb
   import pe_axi_rd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
   input  logic [NUM_REQ*3-1:0]          req_arprot,
   input  logic [NUM_REQ-1:0]            req_arvalid,
   output logic [NUM_REQ-1:0]            req_arready,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic [1:0]                    req_rresp,
   output logic [NUM_REQ-1:0]            req_rvalid,
   input  logic [NUM_REQ-1:0]            req_rready,
   output logic [ADDR_WIDTH-1:0]         m_araddr,
   output logic [2:0]                    m_arprot,
   output logic                          m_arvalid,
   input  logic                          m_arready,
   input  logic [DATA_WIDTH-1:0]         m_rdata,
   input  logic [1:0]                    m_rresp,
   input  logic                          m_rvalid,
   output logic                          m_rready,
   output logic [2:0]                    grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [2:0]              arprot_q, arprot_d;
   logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
   logic [GrantIdW-1:0]     grant_q, grant_d;
   logic [GrantIdW-1:0]     last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0]      arb_oh;
   logic [GrantIdW-1:0]     arb_idx;
   logic                    arb_valid;
   logic [ADDR_WIDTH-1:0]   win_araddr;
   logic [2:0]              win_arprot;
   logic                    rready_g;
   logic                    tmo_fired;

   pe_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i         (req_arvalid),
      .last_grant_i  (last_grant_q),
      .grant_oh_o    (arb_oh),
      .grant_idx_o   (arb_idx),
      .grant_valid_o (arb_valid)
   );

   // Select the winning requester's address and protection bits.
   always_comb begin
      win_araddr = '0;
      win_arprot = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (arb_oh[i]) begin
            win_araddr = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_arprot = req_arprot[i*3 +: 3];
         end
      end
   end

   assign rready_g = |(req_rready & grant_oh_q);

`ifdef PE_AXI_RD_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   // Once the counter saturates, the block answers the requester itself.
   assign tmo_fired   = (state_q == StData) && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES));
   assign timeout_err = timeout_err_q;

   // Timeout counter and sticky error flag next-state.
   always_comb begin
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_q != StData) begin
         tmo_cnt_d = '0;
      end else if (tmo_fired) begin
         if (rready_g) begin
            timeout_err_d = 1'b1;
            tmo_cnt_d     = '0;
         end
      end else if (!m_rvalid) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_fired      = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   // FSM next-state and AR capture.
   always_comb begin
      state_d      = state_q;
      araddr_d     = araddr_q;
      arprot_d     = arprot_q;
      grant_oh_d   = grant_oh_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               araddr_d     = win_araddr;
               arprot_d     = win_arprot;
               grant_oh_d   = arb_oh;
               grant_d      = arb_idx;
               last_grant_d = arb_idx;
               state_d      = StAddr;
            end
         end
         StAddr: begin
            // AR completes even if the requester dropped arvalid.
            if (m_arready) begin
               state_d = StData;
            end
         end
         StData: begin
            if (tmo_fired) begin
               if (rready_g) begin
                  state_d = StDrain;
               end
            end else if (m_rvalid && rready_g) begin
               state_d = StIdle;
            end
         end
`ifdef PE_AXI_RD_ARB_TIMEOUT_EN
         StDrain: begin
            // Late beat from the abandoned transaction is swallowed.
            if (m_rvalid) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // FSM and AR registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         araddr_q     <= '0;
         arprot_q     <= '0;
         grant_oh_q   <= '0;
         grant_q      <= '0;
         last_grant_q <= GrantIdW'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         araddr_q     <= araddr_d;
         arprot_q     <= arprot_d;
         grant_oh_q   <= grant_oh_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign m_araddr  = araddr_q;
   assign m_arprot  = arprot_q;
   assign m_arvalid = (state_q == StAddr);
   assign grant_id  = grant_q;
   assign busy      = (state_q != StIdle);

   // Per-state routing of handshakes and R data to the granted requester.
   always_comb begin
      req_arready = '0;
      req_rvalid  = '0;
      req_rdata   = '0;
      req_rresp   = RespOkay;
      m_rready    = 1'b0;
      unique case (state_q)
         StAddr: begin
            req_arready = grant_oh_q & {NUM_REQ{m_arready}};
         end
         StData: begin
            if (tmo_fired) begin
               req_rvalid = grant_oh_q;
               req_rresp  = RespDecerr;
            end else begin
               req_rvalid = grant_oh_q & {NUM_REQ{m_rvalid}};
               req_rdata  = m_rdata;
               req_rresp  = m_rresp;
               m_rready   = rready_g;
            end
         end
`ifdef PE_AXI_RD_ARB_TIMEOUT_EN
         StDrain: begin
            m_rready = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pe_axi_rd_arb.sv
// Directed self-checking bench for pe_axi_rd_arb (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_pe_axi_rd_arb;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic             clk;
   logic             rst;
   logic [NR*AW-1:0] req_araddr;
   logic [NR*3-1:0]  req_arprot;
   logic [NR-1:0]    req_arvalid;
   logic [NR-1:0]    req_arready;
   logic [DW-1:0]    req_rdata;
   logic [1:0]       req_rresp;
   logic [NR-1:0]    req_rvalid;
   logic [NR-1:0]    req_rready;
   logic [AW-1:0]    m_araddr;
   logic [2:0]       m_arprot;
   logic             m_arvalid;
   logic             m_arready;
   logic [DW-1:0]    m_rdata;
   logic [1:0]       m_rresp;
   logic             m_rvalid;
   logic             m_rready;
   logic [2:0]       grant_id;
   logic             busy;
   logic             timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   pe_axi_rd_arb #(
      .NUM_REQ        (NR),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_araddr  (req_araddr),
      .req_arprot  (req_arprot),
      .req_arvalid (req_arvalid),
      .req_arready (req_arready),
      .req_rdata   (req_rdata),
      .req_rresp   (req_rresp),
      .req_rvalid  (req_rvalid),
      .req_rready  (req_rready),
      .m_araddr    (m_araddr),
      .m_arprot    (m_arprot),
      .m_arvalid   (m_arvalid),
      .m_arready   (m_arready),
      .m_rdata     (m_rdata),
      .m_rresp     (m_rresp),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR-1:0] exp_oh;
      int            exp_g;

      rst         = 1'b1;
      req_araddr  = '0;
      req_arprot  = '0;
      req_arvalid = '0;
      req_rready  = '0;
      m_arready   = 1'b0;
      m_rdata     = '0;
      m_rresp     = 2'b00;
      m_rvalid    = 1'b0;
      step();
      step();

      // Reset values.
      check("rst_arvalid", m_arvalid, 0);
      check("rst_araddr", m_araddr, 0);
      check("rst_arprot", m_arprot, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_rvalid", req_rvalid, 0);
      check("rst_m_rready", m_rready, 0);
      check("rst_arready", req_arready, 0);

      // Single requester 2, addr 0x100, R returns two cycles after AR accept.
      rst = 1'b0;
      req_araddr[2*AW +: AW] = 32'h0000_0100;
      req_arprot[2*3 +: 3]   = 3'b010;
      req_arvalid            = 4'b0100;
      m_arready              = 1'b1;
      #1;
      check("t1_idle_arvalid", m_arvalid, 0);
      step();
      check("t1_arvalid", m_arvalid, 1);
      check("t1_araddr", m_araddr, 32'h100);
      check("t1_arprot", m_arprot, 3'b010);
      check("t1_grant", grant_id, 2);
      check("t1_arready", req_arready, 4'b0100);
      check("t1_busy", busy, 1);
      req_arvalid = '0;
      step();
      check("t1_data_arvalid", m_arvalid, 0);
      check("t1_data_arready", req_arready, 0);
      check("t1_data_rvalid0", req_rvalid, 0);
      step();
      m_rvalid   = 1'b1;
      m_rdata    = 32'hDEAD_BEEF;
      m_rresp    = 2'b00;
      req_rready = 4'b0100;
      #1;
      check("t1_rvalid", req_rvalid, 4'b0100);
      check("t1_rdata", req_rdata, 32'hDEAD_BEEF);
      check("t1_rresp", req_rresp, 2'b00);
      check("t1_m_rready", m_rready, 1);
      step();
      m_rvalid   = 1'b0;
      m_rdata    = '0;
      req_rready = '0;
      #1;
      check("t1_done_busy", busy, 0);
      check("t1_done_rvalid", req_rvalid, 0);
      check("t1_done_rdata", req_rdata, 0);

      // Requester 1 with m_arready stalled 5 cycles; arvalid dropped mid-ADDR.
      req_araddr[1*AW +: AW] = 32'h2222_0000;
      req_arprot[1*3 +: 3]   = 3'b001;
      req_arvalid            = 4'b0010;
      m_arready              = 1'b0;
      step();
      for (int c = 0; c < 5; c++) begin
         if (c == 2) req_arvalid = '0;
         #1;
         check("t3_stall_arvalid", m_arvalid, 1);
         check("t3_stall_araddr", m_araddr, 32'h2222_0000);
         check("t3_stall_arready", req_arready, 0);
         step();
      end
      m_arready = 1'b1;
      #1;
      check("t3_accept_arready", req_arready, 4'b0010);
      check("t3_accept_grant", grant_id, 1);
      check("t3_accept_arprot", m_arprot, 3'b001);
      step();
      m_arready = 1'b0;
      #1;
      check("t3_data_arvalid", m_arvalid, 0);

      // R held by requester backpressure for 3 cycles; SLVERR passes through.
      m_rvalid   = 1'b1;
      m_rdata    = 32'h1234_5678;
      m_rresp    = pe_axi_rd_arb_pkg::RespSlverr;
      req_rready = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t4_hold_m_rready", m_rready, 0);
         check("t4_hold_rvalid", req_rvalid, 4'b0010);
         check("t4_hold_rdata", req_rdata, 32'h1234_5678);
         check("t4_hold_busy", busy, 1);
         step();
      end
      req_rready = 4'b0010;
      #1;
      check("t4_m_rready", m_rready, 1);
      check("t4_rresp", req_rresp, 2'b10);
      step();
      m_rvalid   = 1'b0;
      req_rready = '0;
      #1;
      check("t4_done_busy", busy, 0);

      // Reset in DATA, then requester 0 must win next.
      req_araddr[3*AW +: AW] = 32'h0000_3300;
      req_arprot[3*3 +: 3]   = 3'b111;
      req_araddr[0*AW +: AW] = 32'h0000_0A00;
      req_arvalid            = 4'b1000;
      m_arready              = 1'b1;
      step();
      check("t5_grant3", grant_id, 3);
      step();
      check("t5_data_busy", busy, 1);
      req_arvalid = 4'b1001;
      rst         = 1'b1;
      step();
      check("t5_rst_arvalid", m_arvalid, 0);
      check("t5_rst_araddr", m_araddr, 0);
      check("t5_rst_arprot", m_arprot, 0);
      check("t5_rst_grant", grant_id, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_arready", req_arready, 0);
      check("t5_rst_rvalid", req_rvalid, 0);
      check("t5_rst_m_rready", m_rready, 0);
      check("t5_rst_tmo", timeout_err, 0);
      rst = 1'b0;
      step();
      check("t5_next_grant0", grant_id, 0);
      check("t5_next_araddr", m_araddr, 32'h0000_0A00);
      check("t5_next_arvalid", m_arvalid, 1);
      // Reset mid-ADDR restores last_grant so rotation restarts at 0.
      rst = 1'b1;
      step();
      rst         = 1'b0;
      req_arvalid = '0;
      #1;
      check("t5_addr_rst_busy", busy, 0);
      check("t5_addr_rst_arvalid", m_arvalid, 0);

      // All four requesting: grants rotate 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 4; i++) begin
         req_araddr[i*AW +: AW] = 32'h0000_1000 + 32'(i * 16);
      end
      req_arvalid = 4'b1111;
      req_rready  = 4'b1111;
      m_arready   = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_g  = k % 4;
         exp_oh = 4'b0001 << exp_g;
         step();
         check("rr_grant", grant_id, 64'(exp_g));
         check("rr_araddr", m_araddr, 32'h0000_1000 + 32'(exp_g * 16));
         check("rr_arready", req_arready, exp_oh);
         step();
         m_rvalid = 1'b1;
         m_rdata  = 32'h0000_00A0 + 32'(k);
         m_rresp  = 2'b00;
         #1;
         check("rr_rvalid", req_rvalid, exp_oh);
         check("rr_rdata", req_rdata, 32'h0000_00A0 + 32'(k));
         step();
         m_rvalid = 1'b0;
      end
      req_arvalid = '0;
      req_rready  = '0;
      #1;
      check("rr_end_busy", busy, 0);

`ifdef PE_AXI_RD_ARB_TIMEOUT_EN
      // No R for 16 cycles: error response, sticky flag, late beat drained.
      req_arvalid = 4'b0010;
      m_arready   = 1'b1;
      step();
      check("to_grant", grant_id, 1);
      step();
      req_arvalid = '0;
      m_arready   = 1'b0;
      repeat (15) step();
      check("to_before_rvalid", req_rvalid, 0);
      step();
      check("to_rvalid", req_rvalid, 4'b0010);
      check("to_rresp", req_rresp, 2'b11);
      check("to_rdata", req_rdata, 0);
      check("to_m_rready", m_rready, 0);
      check("to_err_pending", timeout_err, 0);
      step();
      check("to_rvalid_held", req_rvalid, 4'b0010);
      req_rready = 4'b0010;
      step();
      req_rready = '0;
      #1;
      check("to_err_set", timeout_err, 1);
      check("to_drain_rvalid", req_rvalid, 0);
      check("to_drain_m_rready", m_rready, 1);
      check("to_drain_busy", busy, 1);
      repeat (12) step();
      m_rvalid = 1'b1;
      m_rdata  = 32'hBAD0_BAD0;
      #1;
      check("to_late_rvalid", req_rvalid, 0);
      check("to_late_rdata", req_rdata, 0);
      step();
      m_rvalid = 1'b0;
      #1;
      check("to_done_busy", busy, 0);
      check("to_err_sticky", timeout_err, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
